// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   state_t  : FSM encoding (IDLE=0, RUN=1, DONE=2)
//   NIBBLE_W : width of the reused ripple-carry slice
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ripple.sv
// 4-bit ripple-carry adder slice, purely combinational.
// Ports:
//   a, b : 4-bit addends
//   cin  : carry in
//   s    : 4-bit sum
//   c3   : carry out of bit 3
module ripple
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                c3
);

  logic [NIBBLE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c3 = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit ripple slice, one
// nibble per cycle, least-significant nibble first.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, cin sampled on accept)
//   out_valid / out_ready: result handshake (sum, cout held while waiting)
//   busy                 : high while an operation is in RUN or DONE
//   dbg_state            : current FSM state, for observation only
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high. in_ready / out_valid depend on state (and rst) only, never on
// the partner's valid/ready, so there is no combinational loop.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16  // multiple of 4, >= 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output state_t           dbg_state
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = $clog2(NIBBLES + 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_cout;

  ripple u_slice (
    .a   (a_sh_q[NIBBLE_W-1:0]),
    .b   (b_sh_q[NIBBLE_W-1:0]),
    .cin (carry_q),
    .s   (slice_s),
    .c3  (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // New nibble enters at the top so that after NIBBLES shifts the
        // first (least-significant) nibble sits at bits [3:0].
        sum_sh_d = (sum_sh_q >> NIBBLE_W)
                 | (WIDTH'(slice_s) << (WIDTH - NIBBLE_W));
        carry_d  = slice_cout;
        a_sh_d   = a_sh_q >> NIBBLE_W;
        b_sh_d   = b_sh_q >> NIBBLE_W;
        idx_d    = idx_q + 1'b1;
        if (idx_q == IDX_W'(NIBBLES - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // A concurrent in_valid is not looked at here; it is taken in IDLE.
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  // Result is presented only in DONE so partial shift contents never leak.
  assign sum       = out_valid ? sum_sh_q : '0;
  assign cout      = out_valid ? carry_q : 1'b0;
  assign dbg_state = state_q;

endmodule
